// File: rtl/wm_cycle_controller_if.sv
// Purpose : control and status bundle between the front panel / program bank and the cycle sequencer.
// Latency : n/a (signal bundle only).
// Backpr. : none; start is a level sampled in IDLE, abort/pause are levels sampled every cycle.
// Ports   : master drives start/abort/pause and the program fields; slave drives phase, remaining,
//           the three enables, busy, done and error.
interface wm_cycle_controller_if;
  logic       start;
  logic       abort;
  logic       pause;
  logic [4:0] wash_in;
  logic [4:0] rinse_in;
  logic [4:0] spin_in;
  logic [4:0] cloth_in;
  logic [2:0] phase;
  logic [4:0] remaining;
  logic       wash_on;
  logic       rinse_on;
  logic       spin_on;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, abort, pause, wash_in, rinse_in, spin_in, cloth_in,
    input  phase, remaining, wash_on, rinse_on, spin_on, busy, done, error
  );

  modport slave (
    input  start, abort, pause, wash_in, rinse_in, spin_in, cloth_in,
    output phase, remaining, wash_on, rinse_on, spin_on, busy, done, error
  );
endinterface

// File: rtl/wm_cycle_controller.sv
// Purpose : runs wash, rinse and spin in order, each for duration*TICK_DIV unpaused cycles.
// Latency : phase/remaining/done registered (state change visible the cycle after the deciding edge);
//           enables react to pause combinationally in the same cycle.
// Backpr. : none; start ignored outside IDLE, pause freezes timing, abort returns to IDLE.
// Ports   : clk, reset (sync, active-high), bus (wm_cycle_controller_if.slave).
module wm_cycle_controller #(
  parameter int TICK_DIV  = 4,
  parameter int MAX_CLOTH = 20
) (
  input logic                   clk,
  input logic                   reset,
  wm_cycle_controller_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_adv_state;
  logic [4:0]    r_remaining;
  logic [4:0]    w_rem_nxt;
  logic [4:0]    w_adv_rem;
  logic [4:0]    r_wash;
  logic [4:0]    r_rinse;
  logic [4:0]    r_spin;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          w_latch;
  logic          w_tick;
  logic          w_cloth_bad;

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_cloth_bad = (bus.cloth_in == 5'd0) || (bus.cloth_in > 5'(MAX_CLOTH));

  // Phase that follows the current one once it expires: skip zero-length phases.
  always_comb begin
    w_adv_state = S_DONE;
    w_adv_rem   = 5'd0;
    case (r_state)
      S_WASH: begin
        if (r_rinse != 5'd0) begin
          w_adv_state = S_RINSE;
          w_adv_rem   = r_rinse;
        end else if (r_spin != 5'd0) begin
          w_adv_state = S_SPIN;
          w_adv_rem   = r_spin;
        end
      end
      S_RINSE: begin
        if (r_spin != 5'd0) begin
          w_adv_state = S_SPIN;
          w_adv_rem   = r_spin;
        end
      end
      default: begin
        w_adv_state = S_DONE;
        w_adv_rem   = 5'd0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_presc_nxt = r_presc;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          // Entry decision uses the live inputs since they are latched on this same edge.
          w_latch     = 1'b1;
          w_presc_nxt = '0;
          if (w_cloth_bad) begin
            w_state_nxt = S_ERROR;
            w_rem_nxt   = 5'd0;
          end else if (bus.wash_in != 5'd0) begin
            w_state_nxt = S_WASH;
            w_rem_nxt   = bus.wash_in;
          end else if (bus.rinse_in != 5'd0) begin
            w_state_nxt = S_RINSE;
            w_rem_nxt   = bus.rinse_in;
          end else if (bus.spin_in != 5'd0) begin
            w_state_nxt = S_SPIN;
            w_rem_nxt   = bus.spin_in;
          end else begin
            w_state_nxt = S_DONE;
            w_rem_nxt   = 5'd0;
          end
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_rem_nxt   = 5'd0;
          w_presc_nxt = '0;
        end else if (!bus.pause) begin
          if (w_tick) begin
            w_presc_nxt = '0;
            if (r_remaining == 5'd1) begin
              w_state_nxt = w_adv_state;
              w_rem_nxt   = w_adv_rem;
            end else begin
              w_rem_nxt = r_remaining - 5'd1;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = 5'd0;
      end
      S_ERROR: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end
        w_rem_nxt = 5'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = 5'd0;
        w_presc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 5'd0;
      r_presc     <= '0;
      r_wash      <= 5'd0;
      r_rinse     <= 5'd0;
      r_spin      <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_presc     <= w_presc_nxt;
      if (w_latch) begin
        r_wash  <= bus.wash_in;
        r_rinse <= bus.rinse_in;
        r_spin  <= bus.spin_in;
      end
    end
  end

  assign bus.phase     = r_state;
  assign bus.remaining = r_remaining;
  assign bus.done      = (r_state == S_DONE);
  assign bus.error     = (r_state == S_ERROR);
  assign bus.busy      = (r_state == S_WASH) || (r_state == S_RINSE) || (r_state == S_SPIN);
  assign bus.wash_on   = (r_state == S_WASH)  && !bus.pause;
  assign bus.rinse_on  = (r_state == S_RINSE) && !bus.pause;
  assign bus.spin_on   = (r_state == S_SPIN)  && !bus.pause;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Purpose : self-checking bench for wm_cycle_controller; expected phase/remaining trace queued at start.
// Latency : observes outputs 1-2 time units after each rising edge.
// Backpr. : n/a.
module tb_wm_cycle_controller;
  localparam int TD = 4;
  localparam int MC = 20;

  typedef struct packed {
    logic [2:0] ph;
    logic [4:0] rem;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  wm_cycle_controller_if u_if();

  wm_cycle_controller #(.TICK_DIV(TD), .MAX_CLOTH(MC)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Checks every output against an expected (phase, remaining) pair and the current pause level.
  task automatic check_outs(input string tag, input exp_t e);
    logic act_p;
    act_p = !u_if.pause;
    check({tag, ".phase"},     u_if.phase,     e.ph);
    check({tag, ".remaining"}, u_if.remaining, e.rem);
    check({tag, ".wash_on"},   u_if.wash_on,   (e.ph == 3'd1) && act_p);
    check({tag, ".rinse_on"},  u_if.rinse_on,  (e.ph == 3'd2) && act_p);
    check({tag, ".spin_on"},   u_if.spin_on,   (e.ph == 3'd3) && act_p);
    check({tag, ".busy"},      u_if.busy,      (e.ph >= 3'd1) && (e.ph <= 3'd3));
    check({tag, ".done"},      u_if.done,      e.ph == 3'd4);
    check({tag, ".error"},     u_if.error,     e.ph == 3'd5);
  endtask

  // Unpaused trace: each nonzero phase holds value k for TD cycles, k = D..1, then DONE, then IDLE.
  task automatic build_trace(input int w, input int r, input int s);
    int   d[3];
    exp_t e;
    d[0] = w; d[1] = r; d[2] = s;
    exp_q.delete();
    for (int p = 0; p < 3; p++)
      for (int k = d[p]; k >= 1; k--)
        for (int t = 0; t < TD; t++) begin
          e.ph = 3'(p + 1); e.rem = 5'(k);
          exp_q.push_back(e);
        end
    e.ph = 3'd4; e.rem = 5'd0; exp_q.push_back(e);
    e.ph = 3'd0; e.rem = 5'd0; exp_q.push_back(e);
  endtask

  task automatic run_prog(input string tag, input int w, input int r, input int s, input int c,
                          input int pause_at, input int pause_len, input int abort_at, input bit poke);
    exp_t cur;
    exp_t nxt;
    int   cyc;
    build_trace(w, r, s);
    u_if.wash_in  = 5'(w);
    u_if.rinse_in = 5'(r);
    u_if.spin_in  = 5'(s);
    u_if.cloth_in = 5'(c);
    u_if.start    = 1'b1;
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    cyc = 0;
    forever begin
      u_if.start = 1'b0;
      u_if.abort = 1'b0;
      u_if.pause = 1'b0;
      if (cur.ph == 3'd0) begin
        #1 check_outs({tag, ".end"}, cur);
        break;
      end
      if (poke) begin
        u_if.start    = cyc[0];
        u_if.wash_in  = 5'($urandom_range(0, 31));
        u_if.rinse_in = 5'($urandom_range(0, 31));
        u_if.spin_in  = 5'($urandom_range(0, 31));
        u_if.cloth_in = 5'($urandom_range(0, 31));
      end
      if (cyc == abort_at) begin
        u_if.abort = 1'b1;
        nxt.ph = 3'd0; nxt.rem = 5'd0;
        exp_q.delete();
        exp_q.push_back(nxt);
      end else if (cyc >= pause_at && cyc < pause_at + pause_len) begin
        u_if.pause = 1'b1;
        exp_q.push_front(cur);
      end
      #1 check_outs(tag, cur);
      if (exp_q.size() == 0) begin
        check({tag, ".queue_empty"}, 1, 0);
        break;
      end
      nxt = exp_q.pop_front();
      @(posedge clk); #1;
      cur = nxt;
      cyc++;
      if (cyc > 600) begin
        check({tag, ".timeout"}, cyc, 600);
        break;
      end
    end
    u_if.start = 1'b0;
    u_if.abort = 1'b0;
    u_if.pause = 1'b0;
  endtask

  task automatic run_err(input string tag, input int c);
    exp_t e;
    u_if.wash_in  = 5'd2;
    u_if.rinse_in = 5'd1;
    u_if.spin_in  = 5'd1;
    u_if.cloth_in = 5'(c);
    u_if.start    = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    e.ph = 3'd5; e.rem = 5'd0;
    check_outs({tag, ".enter"}, e);
    for (int i = 0; i < 10; i++) begin
      u_if.start    = i[0];
      u_if.cloth_in = 5'd3;
      @(posedge clk); #1;
      check_outs({tag, ".hold"}, e);
    end
    u_if.start = 1'b0;
    u_if.abort = 1'b1;
    @(posedge clk); #1;
    u_if.abort = 1'b0;
    e.ph = 3'd0;
    check_outs({tag, ".abort"}, e);
  endtask

  task automatic reset_mid_spin();
    exp_t e;
    u_if.wash_in  = 5'd0;
    u_if.rinse_in = 5'd0;
    u_if.spin_in  = 5'd3;
    u_if.cloth_in = 5'd1;
    u_if.start    = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    e.ph = 3'd3; e.rem = 5'd2;
    check_outs("pre_reset", e);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    e.ph = 3'd0; e.rem = 5'd0;
    check_outs("mid_spin_reset", e);
  endtask

  initial begin
    exp_t e;
    reset         = 1'b1;
    u_if.start    = 1'b0;
    u_if.abort    = 1'b0;
    u_if.pause    = 1'b0;
    u_if.wash_in  = 5'd0;
    u_if.rinse_in = 5'd0;
    u_if.spin_in  = 5'd0;
    u_if.cloth_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    e.ph = 3'd0; e.rem = 5'd0;
    check_outs("reset", e);
    reset = 1'b0;
    @(posedge clk); #1;
    u_if.abort = 1'b1;
    @(posedge clk); #1;
    u_if.abort = 1'b0;
    check_outs("abort_idle", e);

    run_prog("full_poke",   2, 1, 3, 5,  -1, 0, -1, 1'b1);
    run_prog("spin_only",   0, 0, 2, 1,  -1, 0, -1, 1'b0);
    run_prog("all_zero",    0, 0, 0, 7,  -1, 0, -1, 1'b0);
    run_prog("max_cloth",   1, 0, 0, MC, -1, 0, -1, 1'b0);
    run_prog("pause_wash",  2, 1, 0, 3,   6, 7, -1, 1'b0);
    run_prog("abort_rinse", 1, 2, 1, 4,  -1, 0,  5, 1'b0);
    run_prog("abort_exp",   1, 1, 2, 4,  -1, 0,  7, 1'b0);
    run_err("err_cloth0", 0);
    run_err("err_cloth21", MC + 1);
    reset_mid_spin();
    run_prog("after_reset", 1, 1, 1, 2,  -1, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
